// File: rtl/branch_predictor_pkg.sv
// Shared word size, counter encodings and a saturating statistics adder
// for the next-PC predictor.
package branch_predictor_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef logic [WORD_SIZE-1:0] word_t;

  // Adds up to two events to a 16-bit statistic, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the fetch/decode/execute datapath (master) and the
// next-PC predictor (slave).
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  word_t       pc_if;
  logic        pc_write;
  logic        freeze_ex;
  logic        is_jump_id;
  word_t       pc_id;
  word_t       pred_pc_id;
  word_t       target_id;
  logic        is_branch_ex;
  logic        taken_ex;
  word_t       pc_ex;
  word_t       pred_pc_ex;
  word_t       target_ex;
  word_t       next_pc;
  word_t       pred_pc;
  logic        jump_miss;
  logic        branch_miss;
  logic [15:0] num_branch;
  logic [15:0] num_miss;

  modport master (
    output pc_if, pc_write, freeze_ex, is_jump_id, pc_id, pred_pc_id, target_id,
           is_branch_ex, taken_ex, pc_ex, pred_pc_ex, target_ex,
    input  next_pc, pred_pc, jump_miss, branch_miss, num_branch, num_miss
  );

  modport slave (
    input  pc_if, pc_write, freeze_ex, is_jump_id, pc_id, pred_pc_id, target_id,
           is_branch_ex, taken_ex, pc_ex, pred_pc_ex, target_ex,
    output next_pc, pred_pc, jump_miss, branch_miss, num_branch, num_miss
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter holding one BTB entry's direction
// confidence; a load overrides counting when the entry is reallocated.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);

  logic [1:0] ctr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_reg <= CTR_WNT;
    end else if (load) begin
      ctr_reg <= load_val;
    end else if (inc && ctr_reg != CTR_ST) begin
      ctr_reg <= ctr_reg + 2'd1;
    end else if (dec && ctr_reg != CTR_SNT) begin
      ctr_reg <= ctr_reg - 2'd1;
    end
  end

  assign ctr = ctr_reg;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor: combinational lookup for IF, jump
// resolution at ID, branch resolution at EX, training from both stages.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS   = 3,
  parameter bit PREDICTION = 1'b1
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

  logic                valid_arr   [ENTRIES];
  logic                is_jump_arr [ENTRIES];
  logic [TAG_BITS-1:0] tag_arr     [ENTRIES];
  word_t               target_arr  [ENTRIES];
  logic [1:0]          ctr_arr     [ENTRIES];

  logic [IDX_BITS-1:0] idx_if, idx_id, idx_ex;
  logic [TAG_BITS-1:0] tag_if, tag_id, tag_ex;

  assign idx_if = bus.pc_if[IDX_BITS-1:0];
  assign idx_id = bus.pc_id[IDX_BITS-1:0];
  assign idx_ex = bus.pc_ex[IDX_BITS-1:0];
  assign tag_if = bus.pc_if[WORD_SIZE-1:IDX_BITS];
  assign tag_id = bus.pc_id[WORD_SIZE-1:IDX_BITS];
  assign tag_ex = bus.pc_ex[WORD_SIZE-1:IDX_BITS];

  logic  hit_if, take_if;
  word_t ex_correct;

  assign hit_if  = valid_arr[idx_if] && (tag_arr[idx_if] == tag_if);
  assign take_if = PREDICTION && hit_if && (is_jump_arr[idx_if] || ctr_arr[idx_if][1]);
  assign bus.pred_pc = take_if ? target_arr[idx_if] : bus.pc_if + word_t'(1);

  assign ex_correct      = bus.taken_ex ? bus.target_ex : bus.pc_ex + word_t'(1);
  assign bus.branch_miss = bus.is_branch_ex && (ex_correct != bus.pred_pc_ex);
  // The ID instruction is on the wrong path whenever EX redirects.
  assign bus.jump_miss   = bus.is_jump_id && (bus.target_id != bus.pred_pc_id) && !bus.branch_miss;

  assign bus.next_pc = bus.branch_miss ? ex_correct :
                       bus.jump_miss   ? bus.target_id : bus.pred_pc;

  logic       ex_train, id_train, id_write, ex_hit;
  logic [1:0] ex_load_val;

  assign ex_train    = bus.is_branch_ex && !bus.freeze_ex;
  assign id_train    = bus.is_jump_id && bus.pc_write && !bus.branch_miss;
  assign id_write    = id_train && !(ex_train && idx_ex == idx_id);
  // A jump entry at the branch's slot counts as a fresh allocation.
  assign ex_hit      = valid_arr[idx_ex] && (tag_arr[idx_ex] == tag_ex) && !is_jump_arr[idx_ex];
  assign ex_load_val = bus.taken_ex ? CTR_WT : CTR_WNT;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : gen_entry
      logic                ex_sel, id_sel;
      logic                valid_reg, is_jump_reg;
      logic [TAG_BITS-1:0] tag_reg;
      word_t               target_reg;

      assign ex_sel = ex_train && (idx_ex == IDX_BITS'(gi));
      assign id_sel = id_write && (idx_id == IDX_BITS'(gi));

      sat_counter2 u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     ((ex_sel && !ex_hit) || id_sel),
        .load_val (ex_sel ? ex_load_val : CTR_ST),
        .inc      (ex_sel && ex_hit && bus.taken_ex),
        .dec      (ex_sel && ex_hit && !bus.taken_ex),
        .ctr      (ctr_arr[gi])
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
        end else if (ex_sel || id_sel) begin
          valid_reg <= 1'b1;
        end
      end

      // Payload needs no reset: it is ignored until valid is set.
      always_ff @(posedge clk) begin
        if (ex_sel) begin
          tag_reg     <= tag_ex;
          target_reg  <= bus.target_ex;
          is_jump_reg <= 1'b0;
        end else if (id_sel) begin
          tag_reg     <= tag_id;
          target_reg  <= bus.target_id;
          is_jump_reg <= 1'b1;
        end
      end

      assign valid_arr[gi]   = valid_reg;
      assign is_jump_arr[gi] = is_jump_reg;
      assign tag_arr[gi]     = tag_reg;
      assign target_arr[gi]  = target_reg;
    end
  endgenerate

  logic [15:0] num_branch_reg, num_miss_reg;
  logic [1:0]  ev_branch, ev_miss;

  assign ev_branch = {1'b0, ex_train} + {1'b0, id_train};
  assign ev_miss   = {1'b0, ex_train && bus.branch_miss} + {1'b0, id_train && bus.jump_miss};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_branch_reg <= 16'd0;
      num_miss_reg   <= 16'd0;
    end else begin
      num_branch_reg <= sat_add16(num_branch_reg, ev_branch);
      num_miss_reg   <= sat_add16(num_miss_reg, ev_miss);
    end
  end

  assign bus.num_branch = num_branch_reg;
  assign bus.num_miss   = num_miss_reg;

endmodule
